// File: rtl/s_if_pkg.sv
// Shared widths, frame lengths, frame layouts and state encoding for the S1/S2 serial link.
package s_if_pkg;

    localparam int UP_AW   = 3;
    localparam int UP_DW   = 18;
    localparam int DN_AW   = 5;
    localparam int DN_DW   = 8;
    localparam int UP_FRM  = UP_AW + UP_DW;
    localparam int DN_FRM  = DN_AW + DN_DW;
    localparam int N_WORDS = 2 ** UP_AW;
    localparam int N_BYTES = UP_DW;

    typedef struct packed {
        logic [UP_AW-1:0] addr;
        logic [UP_DW-1:0] data;
    } up_frame_t;

    typedef struct packed {
        logic [DN_AW-1:0] addr;
        logic [DN_DW-1:0] data;
    } dn_frame_t;

    typedef enum logic [2:0] {
        UP_RX,
        UP_WR,
        UP_WAIT,
        DN_RD,
        DN_TX,
        DN_END
    } state_t;

endpackage

// File: rtl/s2_frame_engine_if.sv
// Serial link wires plus the RB2 SRAM port as seen by the S2 frame engine.
interface s2_frame_engine_if;
    import s_if_pkg::*;

    logic             updown;
    logic             sen_in;
    logic             sd_in;
    logic             sen_out;
    logic             sd_out;
    logic             S2_done;
    logic             RB2_RW;
    logic [UP_AW-1:0] RB2_A;
    logic [UP_DW-1:0] RB2_D;
    logic [UP_DW-1:0] RB2_Q;

    modport master (
        input  updown, sen_in, sd_in, RB2_Q,
        output sen_out, sd_out, S2_done, RB2_RW, RB2_A, RB2_D
    );

    modport slave (
        output updown, sen_in, sd_in, RB2_Q,
        input  sen_out, sd_out, S2_done, RB2_RW, RB2_A, RB2_D
    );

endinterface

// File: rtl/s_piso_shift.sv
// Parallel-load MSB-first serialiser: load in cycle t drives W bits with sen low in t+1..t+W.
// No backpressure; a load while still shifting restarts the frame.
module s_piso_shift #(
    parameter int W = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    output logic         sen,
    output logic         sd,
    output logic         last
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  sr;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
            sen <= 1'b1;
            sd  <= 1'b0;
        end else if (load) begin
            sd  <= din[W-1];
            sr  <= {din[W-2:0], 1'b0};
            cnt <= CW'(W - 1);
            sen <= 1'b0;
        end else if (cnt != '0) begin
            sd  <= sr[W-1];
            sr  <= {sr[W-2:0], 1'b0};
            cnt <= cnt - CW'(1);
            sen <= 1'b0;
        end else begin
            sen <= 1'b1;
            sd  <= 1'b0;
        end
    end

    // High while the final bit of the frame is on the line.
    assign last = !sen && (cnt == '0);

endmodule

// File: rtl/s2_frame_engine.sv
// S2 link endpoint: collects 8 upload frames into RB2, then re-reads RB2 and sends 18 transposed frames.
// Write lands 1 cycle after a frame's last bit; each download frame follows a 9-cycle RB2 read burst.
module s2_frame_engine
    import s_if_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    s2_frame_engine_if.master  bus
);
    state_t            state;
    logic [UP_FRM-2:0] sh;
    logic [4:0]        bit_cnt;
    logic [UP_AW-1:0]  frm_cnt;
    logic [DN_AW-1:0]  m;
    logic [3:0]        rd_cnt;
    logic [DN_DW-1:0]  dn_byte;
    logic [DN_DW-1:0]  next_byte;
    logic [4:0]        q_sel;
    logic [2:0]        byte_idx;
    logic              q_bit;
    logic              rx_on;
    logic              rx_last;
    logic              piso_load;
    logic              piso_last;
    up_frame_t         rx_frm;
    dn_frame_t         tx_frm;

    // The frame is complete in the same cycle its last bit is sampled.
    assign rx_frm  = {sh, bus.sd_in};
    assign rx_on   = (state == UP_RX) || (state == UP_WR);
    assign rx_last = rx_on && !bus.sen_in && (bit_cnt == 5'(UP_FRM - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            sh      <= '0;
            bit_cnt <= '0;
        end else if (!rx_on || bus.sen_in) begin
            bit_cnt <= '0;
        end else begin
            sh      <= {sh[UP_FRM-3:0], bus.sd_in};
            bit_cnt <= rx_last ? 5'd0 : bit_cnt + 5'd1;
        end
    end

    // Word n read at rd_cnt=n returns at rd_cnt=n+1 and supplies byte bit 7-n.
    assign q_sel    = 5'(UP_DW - 1) - m;
    assign q_bit    = bus.RB2_Q[q_sel];
    assign byte_idx = 3'(4'(N_WORDS) - rd_cnt);

    always_comb begin
        next_byte           = dn_byte;
        next_byte[byte_idx] = q_bit;
    end

    assign piso_load   = (state == DN_RD) && (rd_cnt == 4'(N_WORDS));
    assign tx_frm.addr = m;
    assign tx_frm.data = next_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= UP_RX;
            frm_cnt     <= '0;
            m           <= '0;
            rd_cnt      <= '0;
            dn_byte     <= '0;
            bus.S2_done <= 1'b0;
            bus.RB2_RW  <= 1'b1;
            bus.RB2_A   <= '0;
            bus.RB2_D   <= '0;
        end else begin
            case (state)
                UP_RX: begin
                    if (rx_last) begin
                        bus.RB2_RW <= 1'b0;
                        bus.RB2_A  <= rx_frm.addr;
                        bus.RB2_D  <= rx_frm.data;
                        state      <= UP_WR;
                    end
                end
                UP_WR: begin
                    bus.RB2_RW <= 1'b1;
                    frm_cnt    <= frm_cnt + 3'd1;
                    if (frm_cnt == 3'(N_WORDS - 1)) begin
                        bus.S2_done <= 1'b1;
                        state       <= UP_WAIT;
                    end else begin
                        state <= UP_RX;
                    end
                end
                UP_WAIT: begin
                    if (bus.updown) begin
                        state     <= DN_RD;
                        m         <= '0;
                        rd_cnt    <= '0;
                        bus.RB2_A <= '0;
                    end
                end
                DN_RD: begin
                    rd_cnt <= rd_cnt + 4'd1;
                    if (rd_cnt != 4'd0) begin
                        dn_byte <= next_byte;
                    end
                    if (rd_cnt < 4'(N_WORDS - 1)) begin
                        bus.RB2_A <= bus.RB2_A + 3'd1;
                    end
                    if (piso_load) begin
                        rd_cnt <= '0;
                        state  <= DN_TX;
                    end
                end
                DN_TX: begin
                    if (piso_last) begin
                        bus.RB2_A <= '0;
                        if (m == 5'(N_BYTES - 1)) begin
                            state <= DN_END;
                        end else begin
                            m     <= m + 5'd1;
                            state <= DN_RD;
                        end
                    end
                end
                DN_END: begin
                end
                default: state <= UP_RX;
            endcase
        end
    end

    s_piso_shift #(
        .W (DN_FRM)
    ) u_piso (
        .clk  (clk),
        .rst  (rst),
        .load (piso_load),
        .din  (tx_frm),
        .sen  (bus.sen_out),
        .sd   (bus.sd_out),
        .last (piso_last)
    );

endmodule

// File: tb/tb_s2_frame_engine.sv
// Directed bench for s2_frame_engine with a synchronous RB2 SRAM model.
module tb_s2_frame_engine;
    import s_if_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    s2_frame_engine_if bus();

    s2_frame_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [17:0] mem [8];
    logic [17:0] q;
    int          wr_cnt = 0;
    logic        tb_we = 1'b0;
    logic [2:0]  tb_wa = '0;
    logic [17:0] tb_wd = '0;

    always @(posedge clk) begin
        if (tb_we) begin
            mem[tb_wa] <= tb_wd;
        end else if (!bus.RB2_RW) begin
            mem[bus.RB2_A] <= bus.RB2_D;
            wr_cnt <= wr_cnt + 1;
        end
        q <= mem[bus.RB2_A];
    end
    assign bus.RB2_Q = q;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_sen_out"}, 32'(bus.sen_out), 32'd1);
        chk({tag, "_sd_out"},  32'(bus.sd_out),  32'd0);
        chk({tag, "_done"},    32'(bus.S2_done), 32'd0);
        chk({tag, "_rw"},      32'(bus.RB2_RW),  32'd1);
        chk({tag, "_a"},       32'(bus.RB2_A),   32'd0);
        chk({tag, "_d"},       32'(bus.RB2_D),   32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.sen_in = 1'b1;
        bus.sd_in = 1'b0;
        bus.updown = 1'b0;
        tb_we = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_bits(input logic [20:0] f, input int nb);
        for (int i = 20; i > 20 - nb; i--) begin
            @(negedge clk);
            bus.sen_in = 1'b0;
            bus.sd_in = f[i];
        end
        @(negedge clk);
        bus.sen_in = 1'b1;
        bus.sd_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [2:0] addr_of(input int mode, input int k);
        logic [2:0] ord [8] = '{3'd7, 3'd3, 3'd0, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4};
        return (mode == 0) ? 3'(k) : ord[k];
    endfunction

    function automatic logic [17:0] data_of(input int mode, input logic [2:0] a);
        return (mode == 0) ? (18'h2AAAA ^ 18'(a)) : (18'h15555 + 18'(a) * 18'h00421);
    endfunction

    task automatic upload(input int mode);
        logic [2:0] a;
        for (int k = 0; k < 8; k++) begin
            a = addr_of(mode, k);
            send_bits({a, data_of(mode, a)}, 21);
            chk($sformatf("up%0d_done_k%0d", mode, k), 32'(bus.S2_done), (k == 7) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic check_mem(input int mode);
        for (int n = 0; n < 8; n++)
            chk($sformatf("up%0d_mem%0d", mode, n), 32'(mem[n]), 32'(data_of(mode, 3'(n))));
    endtask

    task automatic tb_wr(input logic [2:0] a, input logic [17:0] d);
        @(negedge clk);
        tb_we = 1'b1;
        tb_wa = a;
        tb_wd = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    // RB1 byte i = i, stored transposed: RB2[n][17-i] = RB1[i][7-n].
    task automatic preload_transposed();
        logic [17:0] w;
        logic [7:0]  b;
        for (int n = 0; n < 8; n++) begin
            w = '0;
            for (int i = 0; i < 18; i++) begin
                b = 8'(i);
                w[17 - i] = b[7 - n];
            end
            tb_wr(3'(n), w);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int mode, input int m);
        if (mode == 0) return 8'(m);
        if (m <= 14) return (m % 2 == 1) ? 8'hFF : 8'h00;
        if (m == 15) return 8'hF0;
        if (m == 16) return 8'h33;
        return 8'hAA;
    endfunction

    task automatic rx_frame(output logic [12:0] f, output logic ok);
        int t;
        t = 0;
        ok = 1'b1;
        f = '0;
        @(negedge clk);
        while (bus.sen_out && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (bus.sen_out) begin
            ok = 1'b0;
            return;
        end
        f[12] = bus.sd_out;
        for (int b = 11; b >= 0; b--) begin
            @(negedge clk);
            if (bus.sen_out) ok = 1'b0;
            f[b] = bus.sd_out;
        end
        @(negedge clk);
        if (!bus.sen_out) ok = 1'b0;
    endtask

    task automatic download(input int mode, input int nfrm);
        logic [12:0] f;
        logic        ok;
        for (int m = 0; m < nfrm; m++) begin
            rx_frame(f, ok);
            chk($sformatf("dn%0d_frm%0d", mode, m), 32'(f), 32'({5'(m), exp_byte(mode, m)}));
            chk($sformatf("dn%0d_len%0d", mode, m), 32'(ok), 32'd1);
        end
    endtask

    task automatic check_idle(input string tag);
        int lows;
        lows = 0;
        repeat (30) begin
            @(negedge clk);
            if (!bus.sen_out || bus.sd_out) lows++;
        end
        chk(tag, 32'(lows), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int t;
        bus.updown = 1'b0;
        bus.sen_in = 1'b1;
        bus.sd_in = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("rst0");
        rst = 1'b0;

        // In-order upload
        w0 = wr_cnt;
        upload(0);
        check_mem(0);
        chk("t1_writes", 32'(wr_cnt - w0), 32'd8);

        // Scrambled address order
        do_reset();
        w0 = wr_cnt;
        upload(1);
        check_mem(1);
        chk("t2_writes", 32'(wr_cnt - w0), 32'd8);

        // Aborted partial frame followed by a full one
        do_reset();
        w0 = wr_cnt;
        send_bits({3'd5, 18'h3FFFF}, 10);
        chk("t3_partial_writes", 32'(wr_cnt - w0), 32'd0);
        send_bits({3'd2, 18'h12345}, 21);
        chk("t3_writes", 32'(wr_cnt - w0), 32'd1);
        chk("t3_mem2", 32'(mem[2]), 32'h12345);
        chk("t3_done", 32'(bus.S2_done), 32'd0);

        // Download of transposed RB1 = 0..17
        do_reset();
        upload(0);
        preload_transposed();
        @(negedge clk);
        bus.updown = 1'b1;
        download(0, 18);
        check_idle("t4_end_idle");
        bus.updown = 1'b0;
        check_idle("t4_updown_low_idle");

        // RB2 modified after upload
        do_reset();
        upload(0);
        for (int n = 0; n < 8; n++) tb_wr(3'(n), ~(18'h2AAAA ^ 18'(n)));
        @(negedge clk);
        bus.updown = 1'b1;
        download(1, 18);

        // Resets mid-upload and mid-download, then a clean rerun
        do_reset();
        for (int k = 0; k < 4; k++) send_bits({3'(k), data_of(0, 3'(k))}, 21);
        w0 = wr_cnt;
        for (int i = 20; i > 10; i--) begin
            @(negedge clk);
            bus.sen_in = 1'b0;
            bus.sd_in = i[0];
        end
        rst = 1'b1;
        @(negedge clk);
        check_reset("t6_up");
        chk("t6_up_writes", 32'(wr_cnt - w0), 32'd0);
        bus.sen_in = 1'b1;
        rst = 1'b0;
        upload(0);
        preload_transposed();
        @(negedge clk);
        bus.updown = 1'b1;
        download(0, 9);
        t = 0;
        while (bus.sen_out && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("t6_frm9_start", 32'(bus.sen_out), 32'd0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        bus.updown = 1'b0;
        @(negedge clk);
        check_reset("t6_dn");
        rst = 1'b0;
        upload(1);
        check_mem(1);
        preload_transposed();
        @(negedge clk);
        bus.updown = 1'b1;
        download(0, 18);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
